// File: rtl/fuzzy_pkg.sv
// Shared types and helpers for the fuzzy coprocessor loop controller.
//   temp_t       : signed 8-bit temperature / delta-temperature value
//   loop_state_t : controller sequencing states
//   sat8         : clamp a signed 9-bit value into the signed 8-bit range
package fuzzy_pkg;

    typedef logic signed [7:0] temp_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_RES,
        WAIT_TICK
    } loop_state_t;

    // The top two bits disagree exactly when the value falls outside [-128, 127].
    function automatic temp_t sat8(input logic signed [8:0] x);
        if (x[8] != x[7]) begin
            return x[8] ? temp_t'(8'h80) : temp_t'(8'h7F);
        end
        return temp_t'(x[7:0]);
    endfunction

endpackage

// File: rtl/loop_timer.sv
// Loadable down-counter that stops at zero.
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load
//   value      : current count
//   zero       : count is zero
module loop_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/fuzzy_loop_ctrl.sv
// Closed-loop sequencer for the fuzzy coprocessor core. Each period it takes a
// temperature sample, forms dT against the previous sample, starts the core and
// waits for its result under a watchdog.
//   clk, rst_n          : clock, asynchronous active-low reset
//   en, period, clr_err : loop enable, cycles between runs (0 acts as 1), error clear
//   s_valid/s_ready/s_T : sensor sample handshake
//   cp_start/cp_init    : core start pulse and init qualifier
//   cp_T/cp_dT          : registered operands to the core
//   cp_valid/cp_G       : core result
//   res_G/res_valid     : last captured result and its one-cycle strobe
//   busy, err_timeout   : not idle, sticky watchdog flag
//   run_cnt             : completed runs (wraps)
module fuzzy_loop_ctrl
    import fuzzy_pkg::*;
#(
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    input  logic                clr_err,
    input  logic                s_valid,
    output logic                s_ready,
    input  temp_t               s_T,
    output logic                cp_start,
    output logic                cp_init,
    output temp_t               cp_T,
    output temp_t               cp_dT,
    input  logic                cp_valid,
    input  logic [7:0]          cp_G,
    output logic [7:0]          res_G,
    output logic                res_valid,
    output logic                busy,
    output logic                err_timeout,
    output logic [7:0]          run_cnt
);

    // One timer serves both the watchdog and the period wait; they never overlap.
    localparam int unsigned TW = (PERIOD_W > $clog2(TIMEOUT)) ? PERIOD_W : $clog2(TIMEOUT);

    loop_state_t state_q, state_d;
    logic        first_q, first_d;
    temp_t       t_prev_q, t_prev_d;
    temp_t       cp_t_q, cp_t_d;
    temp_t       cp_dt_q, cp_dt_d;
    logic [7:0]  res_g_q, res_g_d;
    logic        res_valid_q, res_valid_d;
    logic        err_q, err_d;
    logic [7:0]  run_cnt_q, run_cnt_d;

    logic                tmr_load;
    logic [TW-1:0]       tmr_val;
    logic                tmr_zero;
    logic [TW-1:0]       unused_tmr_value;
    logic [PERIOD_W-1:0] period_ld;
    logic signed [8:0]   diff;
    logic                run_done;

    loop_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (unused_tmr_value),
        .zero     (tmr_zero)
    );

    // Loaded on WAIT_TICK entry so the state lasts max(period,1) cycles.
    assign period_ld = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign diff      = {s_T[7], s_T} - {t_prev_q[7], t_prev_q};

    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        t_prev_d    = t_prev_q;
        cp_t_d      = cp_t_q;
        cp_dt_d     = cp_dt_q;
        res_g_d     = res_g_q;
        res_valid_d = 1'b0;
        err_d       = err_q;
        run_cnt_d   = run_cnt_q;
        tmr_load    = 1'b0;
        tmr_val     = TW'(TIMEOUT - 1);
        run_done    = 1'b0;

        // A timeout firing below overrides this clear.
        if (clr_err) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                first_d = 1'b1;
                if (en) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!en) begin
                    state_d = IDLE;
                    first_d = 1'b1;
                end else if (s_valid) begin
                    cp_t_d   = s_T;
                    cp_dt_d  = first_q ? temp_t'(8'h00) : sat8(diff);
                    t_prev_d = s_T;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                first_d  = 1'b0;
                tmr_load = 1'b1;
                tmr_val  = TW'(TIMEOUT - 1);
                state_d  = WAIT_RES;
            end
            WAIT_RES: begin
                // A result arriving on the last watchdog cycle still counts.
                if (cp_valid) begin
                    res_g_d     = cp_G;
                    res_valid_d = 1'b1;
                    run_cnt_d   = run_cnt_q + 8'd1;
                    run_done    = 1'b1;
                end else if (tmr_zero) begin
                    err_d    = 1'b1;
                    first_d  = 1'b1;
                    run_done = 1'b1;
                end
                if (run_done) begin
                    if (en) begin
                        state_d  = WAIT_TICK;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(period_ld);
                    end else begin
                        state_d = IDLE;
                        first_d = 1'b1;
                    end
                end
            end
            WAIT_TICK: begin
                if (!en) begin
                    state_d = IDLE;
                    first_d = 1'b1;
                end else if (tmr_zero) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
                first_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            first_q     <= 1'b1;
            t_prev_q    <= '0;
            cp_t_q      <= '0;
            cp_dt_q     <= '0;
            res_g_q     <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            run_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            t_prev_q    <= t_prev_d;
            cp_t_q      <= cp_t_d;
            cp_dt_q     <= cp_dt_d;
            res_g_q     <= res_g_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            run_cnt_q   <= run_cnt_d;
        end
    end

    assign s_ready     = (state_q == FETCH) && en;
    assign cp_start    = (state_q == ISSUE);
    assign cp_init     = (state_q == ISSUE) && first_q;
    assign cp_T        = cp_t_q;
    assign cp_dT       = cp_dt_q;
    assign res_G       = res_g_q;
    assign res_valid   = res_valid_q;
    assign busy        = (state_q != IDLE);
    assign err_timeout = err_q;
    assign run_cnt     = run_cnt_q;

endmodule

// File: tb/tb_fuzzy_loop_ctrl.sv
// Scoreboard bench for fuzzy_loop_ctrl: directed runs push expected core starts
// and results into queues; a negedge monitor pops and compares them.
module tb_fuzzy_loop_ctrl;

    localparam int TMO = 16;

    typedef struct {
        logic       init;
        logic [7:0] t;
        logic [7:0] dt;
    } start_t;

    typedef struct {
        logic [7:0] g;
        logic [7:0] cnt;
    } res_t;

    typedef struct {
        int         gap;
        logic [7:0] t;
    } smp_t;

    logic        clk, rst_n, en, clr_err;
    logic [15:0] period;
    logic        s_valid, s_ready, cp_start, cp_init, cp_valid, res_valid, busy, err_timeout;
    logic [7:0]  s_T, cp_T, cp_dT, cp_G, res_G, run_cnt;

    start_t exp_start[$];
    res_t   exp_res[$];
    smp_t   sq[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int core_lat = 5;

    start_t     mon_s;
    res_t       mon_r;
    smp_t       sens_e;
    int         core_n;
    logic [7:0] core_g;

    fuzzy_loop_ctrl #(
        .PERIOD_W (16),
        .TIMEOUT  (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .period      (period),
        .clr_err     (clr_err),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_T         (s_T),
        .cp_start    (cp_start),
        .cp_init     (cp_init),
        .cp_T        (cp_T),
        .cp_dT       (cp_dT),
        .cp_valid    (cp_valid),
        .cp_G        (cp_G),
        .res_G       (res_G),
        .res_valid   (res_valid),
        .busy        (busy),
        .err_timeout (err_timeout),
        .run_cnt     (run_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_run(input logic init, input logic [7:0] t, input logic [7:0] dt,
                            input logic [7:0] g, input logic [7:0] cnt);
        exp_start.push_back('{init, t, dt});
        exp_res.push_back('{g, cnt});
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        while (!cp_start && n < 500) begin
            step();
            n++;
        end
        if (!cp_start) chk({nm, " start wait"}, 0, 1);
    endtask

    task automatic wait_runs(input logic [7:0] target);
        int n = 0;
        while (run_cnt != target && n < 1000) begin
            step();
            n++;
        end
        chk("run_cnt", run_cnt, target);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " s_ready"}, s_ready, 0);
        chk({tag, " cp_start"}, cp_start, 0);
        chk({tag, " cp_init"}, cp_init, 0);
        chk({tag, " cp_T"}, cp_T, 0);
        chk({tag, " cp_dT"}, cp_dT, 0);
        chk({tag, " res_G"}, res_G, 0);
        chk({tag, " res_valid"}, res_valid, 0);
        chk({tag, " err_timeout"}, err_timeout, 0);
        chk({tag, " run_cnt"}, run_cnt, 0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cp_start) begin
                if (exp_start.size() == 0) begin
                    chk("unexpected cp_start", 1, 0);
                end else begin
                    mon_s = exp_start.pop_front();
                    chk("cp_init", cp_init, mon_s.init);
                    chk("cp_T", cp_T, mon_s.t);
                    chk("cp_dT", cp_dT, mon_s.dt);
                end
            end
            if (res_valid) begin
                if (exp_res.size() == 0) begin
                    chk("unexpected res_valid", 1, 0);
                end else begin
                    mon_r = exp_res.pop_front();
                    chk("res_G", res_G, mon_r.g);
                    chk("res run_cnt", run_cnt, mon_r.cnt);
                end
            end
        end
    end

    // Core responder: G = T + 3 after core_lat cycles; negative latency never answers.
    initial begin
        cp_valid = 1'b0;
        cp_G = 8'h00;
        forever begin
            @(negedge clk);
            if (cp_start && core_lat >= 0) begin
                core_n = core_lat;
                core_g = cp_T + 8'd3;
                repeat (core_n) @(posedge clk);
                #1;
                cp_valid = 1'b1;
                cp_G = core_g;
                @(posedge clk);
                #1;
                cp_valid = 1'b0;
            end
        end
    end

    // Sensor: each queued sample appears after its gap and is held until accepted.
    initial begin
        s_valid = 1'b0;
        s_T = 8'h00;
        forever begin
            if (sq.size() == 0) begin
                s_valid = 1'b0;
                @(posedge clk);
                #1;
            end else begin
                sens_e = sq.pop_front();
                s_valid = 1'b0;
                repeat (sens_e.gap) begin
                    @(posedge clk);
                    #1;
                end
                s_T = sens_e.t;
                s_valid = 1'b1;
                do @(negedge clk); while (!s_ready);
                @(posedge clk);
                #1;
                s_valid = 1'b0;
            end
        end
    end

    initial begin
        int c0;
        rst_n = 1'b0;
        en = 1'b0;
        clr_err = 1'b0;
        period = 16'd10;
        repeat (3) step();
        chk_zero("reset");
        rst_n = 1'b1;
        step();

        // Basic loop, period 10, core latency 5.
        push_run(1'b1, 8'd20, 8'd0, 8'd23, 8'd1);
        push_run(1'b0, 8'd25, 8'd5, 8'd28, 8'd2);
        sq.push_back('{0, 8'd20});
        sq.push_back('{0, 8'd25});
        en = 1'b1;
        wait_start("basic1");
        c0 = cyc;
        step();
        wait_start("basic2");
        chk("start spacing p10", cyc - c0, 17);
        wait_runs(8'd2);

        // Saturation of dT.
        push_run(1'b0, 8'd100, 8'd75, 8'd103, 8'd3);
        push_run(1'b0, 8'(-100), 8'h80, 8'(-97), 8'd4);
        push_run(1'b0, 8'd100, 8'h7F, 8'd103, 8'd5);
        sq.push_back('{0, 8'd100});
        sq.push_back('{0, 8'(-100)});
        sq.push_back('{0, 8'd100});
        wait_runs(8'd5);

        // Watchdog timeout.
        core_lat = -1;
        exp_start.push_back('{1'b0, 8'd10, 8'(-90)});
        sq.push_back('{0, 8'd10});
        wait_start("timeout");
        repeat (TMO) step();
        chk("err before timeout", err_timeout, 0);
        step();
        chk("err at timeout", err_timeout, 1);
        chk("res_valid on timeout", res_valid, 0);
        chk("run_cnt on timeout", run_cnt, 5);
        repeat (3) step();
        chk("err sticky", err_timeout, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("err cleared", err_timeout, 0);
        core_lat = 5;
        push_run(1'b1, 8'd30, 8'd0, 8'd33, 8'd6);
        sq.push_back('{0, 8'd30});
        wait_runs(8'd6);

        // Result on the final watchdog cycle.
        core_lat = TMO;
        push_run(1'b0, 8'd40, 8'd10, 8'd43, 8'd7);
        sq.push_back('{0, 8'd40});
        wait_runs(8'd7);
        chk("err after edge valid", err_timeout, 0);

        // en dropped in WAIT_RES: run completes, then idle.
        core_lat = 5;
        push_run(1'b0, 8'd50, 8'd10, 8'd53, 8'd8);
        sq.push_back('{0, 8'd50});
        wait_start("en drop res");
        step();
        step();
        en = 1'b0;
        wait_runs(8'd8);
        chk("busy after run", busy, 0);
        step();
        chk("busy idle", busy, 0);

        // en dropped in FETCH with no sample.
        en = 1'b1;
        for (int i = 0; i < 20 && !s_ready; i++) step();
        chk("fetch s_ready", s_ready, 1);
        en = 1'b0;
        step();
        chk("fetch drop busy", busy, 0);
        chk("fetch drop s_ready", s_ready, 0);
        repeat (5) step();
        push_run(1'b1, 8'd60, 8'd0, 8'd63, 8'd9);
        sq.push_back('{0, 8'd60});
        en = 1'b1;
        wait_runs(8'd9);

        // period 0 and sensor back-pressure.
        period = 16'd0;
        push_run(1'b0, 8'd70, 8'd10, 8'd73, 8'd10);
        push_run(1'b0, 8'd80, 8'd10, 8'd83, 8'd11);
        push_run(1'b0, 8'd90, 8'd10, 8'd93, 8'd12);
        sq.push_back('{0, 8'd70});
        sq.push_back('{0, 8'd80});
        sq.push_back('{14, 8'd90});
        wait_start("p0 a");
        c0 = cyc;
        step();
        wait_start("p0 b");
        chk("start spacing p0", cyc - c0, 8);
        c0 = cyc;
        repeat (7) step();
        for (int i = 0; i < 7; i++) begin
            chk("stall ready/no start", {30'd0, s_ready, cp_start}, 32'd2);
            step();
        end
        wait_start("p0 c");
        chk("start after stall", cyc - c0, 15);
        wait_runs(8'd12);

        // Asynchronous reset in WAIT_RES.
        core_lat = -1;
        exp_start.push_back('{1'b0, 8'(-5), 8'(-95)});
        sq.push_back('{0, 8'(-5)});
        wait_start("reset run");
        repeat (3) step();
        chk("busy before reset", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async reset");

        chk("start queue drained", exp_start.size(), 0);
        chk("result queue drained", exp_res.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
